// File: rtl/fb_swap_scheduler_if.sv
// Bundle of PPU-side and framebuffer-side signals around the buffer swap scheduler.
//   master : PPU/scanout/testbench side, drives the strobes and reads the buffer controls
//   slave  : scheduler side
// Signals:
//   ppu_wren, ppu_frame_done, ppu_frame_start, scan_frame_end, lcd_enable  (to scheduler)
//   buf0_wren, buf1_wren, front_sel, swap_pulse, blank_out, drop_cnt       (from scheduler)
interface fb_swap_scheduler_if #(
    parameter int unsigned DROP_CNT_W = 8
);
    logic                  ppu_wren;
    logic                  ppu_frame_done;
    logic                  ppu_frame_start;
    logic                  scan_frame_end;
    logic                  lcd_enable;
    logic                  buf0_wren;
    logic                  buf1_wren;
    logic                  front_sel;
    logic                  swap_pulse;
    logic                  blank_out;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output ppu_wren, ppu_frame_done, ppu_frame_start, scan_frame_end, lcd_enable,
        input  buf0_wren, buf1_wren, front_sel, swap_pulse, blank_out, drop_cnt
    );

    modport slave (
        input  ppu_wren, ppu_frame_done, ppu_frame_start, scan_frame_end, lcd_enable,
        output buf0_wren, buf1_wren, front_sel, swap_pulse, blank_out, drop_cnt
    );
endinterface

// File: rtl/fb_swap_scheduler.sv
// Front/back buffer selection for the double-buffered 160x144 2-bit framebuffer.
// PPU writes are steered to the back buffer only while rendering; buffers swap once
// the PPU has completed a frame and scanout has finished its visible frame (or scanout
// stalls past TIMEOUT_CYCLES). Frames the PPU starts while a swap is pending are dropped
// and counted.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   fb      : scheduler side of fb_swap_scheduler_if (strobes in, buffer controls out)
module fb_swap_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned DROP_CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    fb_swap_scheduler_if.slave fb
);

    localparam int unsigned    TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StRender, StWaitScan, StSwap, StDrop} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic                  r_fd_q;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  r_front_sel;
    logic                  r_swap_pulse;
    logic                  r_frame_valid;
    logic                  r_blank;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic w_fd_rise;
    logic w_to_last;
    logic w_enter_swap;
    logic w_enter_drop;
    logic w_count;

    assign w_fd_rise    = fb.ppu_frame_done & ~r_fd_q;
    assign w_to_last    = (r_to_cnt == TO_LAST);
    assign w_enter_swap = (w_state_next == StSwap);
    assign w_enter_drop = (r_state == StWaitScan) && (w_state_next == StDrop);
    // Timer runs through WAIT_SCAN and DROP; any other path clears it.
    assign w_count      = ((r_state == StWaitScan) || (r_state == StDrop)) &&
                          ((w_state_next == StWaitScan) || (w_state_next == StDrop));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StRender;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; lcd off wins over everything so a dark display never swaps.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StRender: begin
                if (w_fd_rise && fb.lcd_enable) w_state_next = StWaitScan;
            end
            StWaitScan: begin
                if (!fb.lcd_enable)              w_state_next = StRender;
                else if (fb.scan_frame_end)      w_state_next = StSwap;
                else if (w_to_last)              w_state_next = StSwap;
                else if (fb.ppu_frame_start)     w_state_next = StDrop;
            end
            StDrop: begin
                if (!fb.lcd_enable)                          w_state_next = StRender;
                else if (fb.scan_frame_end || w_to_last)     w_state_next = StSwap;
            end
            StSwap:   w_state_next = StRender;
            default:  w_state_next = StRender;
        endcase
    end

    // Registered outputs and bookkeeping; front_sel/swap_pulse update on entry to SWAP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fd_q        <= 1'b0;
            r_to_cnt      <= '0;
            r_front_sel   <= 1'b0;
            r_swap_pulse  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_blank       <= 1'b1;
            r_drop_cnt    <= '0;
        end else begin
            r_fd_q       <= fb.ppu_frame_done;
            r_swap_pulse <= w_enter_swap;
            r_blank      <= ~fb.lcd_enable | ~r_frame_valid;
            if (w_enter_swap) begin
                r_front_sel   <= ~r_front_sel;
                r_frame_valid <= 1'b1;
            end
            if (w_count) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
            if (w_enter_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    // Output logic; write gating is combinational and also killed by reset directly so
    // writes stop the instant reset_n falls.
    always_comb begin
        fb.buf0_wren = 1'b0;
        fb.buf1_wren = 1'b0;
        if (reset_n && (r_state == StRender)) begin
            if (r_front_sel) begin
                fb.buf0_wren = fb.ppu_wren;
            end else begin
                fb.buf1_wren = fb.ppu_wren;
            end
        end
        fb.front_sel  = r_front_sel;
        fb.swap_pulse = r_swap_pulse;
        fb.blank_out  = r_blank;
        fb.drop_cnt   = r_drop_cnt;
    end

endmodule

// File: doc/fb_swap_scheduler.md
Name: fb_swap_scheduler

Overview:
Single-clock controller that owns front/back selection for the double-buffered 160x144 2-bit framebuffer. It gates PPU pixel writes into the back buffer and swaps buffers only at a safe point: the PPU has finished a frame and the scanout side has finished its visible frame. It counts dropped frames and forces a swap if scanout stalls. It sits between the PPU write path and the two framebuffer RAM write enables. The read mux is driven by front_sel.

Parameters:
TIMEOUT_CYCLES, 24'd2000000, cycles in WAIT_SCAN before a forced swap.
DROP_CNT_W, 8, width of the saturating dropped-frame counter.

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
ppu_wren  in  1  PPU pixel write strobe
ppu_frame_done  in  1  level; rises when PPU enters vblank (edge-detected internally)
ppu_frame_start  in  1  1-cycle pulse; PPU begins line 0 of a new frame
scan_frame_end  in  1  1-cycle pulse; scanout finished last visible pixel (Y_read>=144)
lcd_enable  in  1  PPU LCD enable; 0 = display off
buf0_wren  out  1  write enable to buffer 0
buf1_wren  out  1  write enable to buffer 1
front_sel  out  1  buffer currently scanned out (0/1)
swap_pulse  out  1  1-cycle pulse on the cycle front_sel toggles
blank_out  out  1  1 = scanout must display white (lcd off or no frame yet)
drop_cnt  out  DROP_CNT_W  saturating count of dropped PPU frames

Behaviour:
- Reset values: front_sel=0, buf0_wren=0, buf1_wren=0, swap_pulse=0, blank_out=1, drop_cnt=0, state=RENDER, timeout counter=0, frame_valid=0.
- Write gating is combinational.
  - In RENDER: buf(~front_sel)_wren = ppu_wren; buf(front_sel)_wren = 0.
  - In WAIT_SCAN, SWAP and DROP: both wren = 0.
  - The front buffer is never written in any state.
- ppu_frame_done is edge-detected with a registered copy. fd_rise = ppu_frame_done & ~fd_q.
- States:
  - RENDER:
    - fd_rise & lcd_enable -> WAIT_SCAN; clear timeout counter.
    - fd_rise & ~lcd_enable -> stay in RENDER (frame discarded, not counted as a drop).
  - WAIT_SCAN:
    - The timeout counter increments each cycle.
    - scan_frame_end -> SWAP.
    - Counter reaches TIMEOUT_CYCLES-1 -> SWAP (forced).
    - ppu_frame_start before either of the above -> DROP.
    - Priority when simultaneous: scan_frame_end > timeout > ppu_frame_start.
  - DROP:
    - The PPU is rendering a frame that will not be stored; writes stay blocked.
    - drop_cnt increments once on entry and saturates at all-ones.
    - scan_frame_end -> SWAP; the previously completed back buffer is still intact.
    - Timeout continues counting and also exits to SWAP.
    - fd_rise in DROP -> stay in DROP; no extra count.
  - SWAP (exactly 1 cycle):
    - front_sel toggles and swap_pulse=1.
    - frame_valid set to 1.
    - Next state RENDER.
    - Writes resume on the next cycle into the new back buffer; a PPU frame already in progress is partially lost, which is accepted.
- blank_out = ~lcd_enable | ~frame_valid, registered (1-cycle latency).
- lcd_enable falling in WAIT_SCAN or DROP -> RENDER, no swap, timeout counter cleared. frame_valid is unchanged, but blank_out=1 via lcd_enable.
- Latency:
  - scan_frame_end in WAIT_SCAN at cycle N -> SWAP state at N+1.
  - front_sel new value and swap_pulse high at N+1, registered out of the SWAP transition.
- Timeout counter width: ceil(log2(TIMEOUT_CYCLES)); no wrap, because the state exits at the terminal value.
- reset_n asserted mid-frame returns everything to reset values immediately, asynchronously. Writes stop the same instant.

Test Plan:
1. Reset release, lcd_enable=1, ppu_wren=1 -> buf1_wren=1, buf0_wren=0, front_sel=0, blank_out=1.
2. fd_rise at cycle 10, scan_frame_end pulse at cycle 50 -> both wren=0 in cycles 11-51. swap_pulse high and front_sel=1 at cycle 51. buf0_wren follows ppu_wren from cycle 52. blank_out=0 from cycle 52.
3. fd_rise, then ppu_frame_start before scan_frame_end -> DROP, drop_cnt=1, no writes. scan_frame_end -> swap; repeating 256 drops holds drop_cnt at 255.
4. TIMEOUT_CYCLES=100, fd_rise, no scan_frame_end -> swap_pulse exactly 100 cycles after entering WAIT_SCAN.
5. scan_frame_end, timeout terminal and ppu_frame_start all in the same cycle -> SWAP taken, drop_cnt unchanged.
6. lcd_enable=0 during WAIT_SCAN -> back to RENDER with no swap and blank_out=1. A later fd_rise with lcd_enable=0 causes no state change. Async reset_n pulse mid-WAIT_SCAN -> all outputs at reset values without a clock edge.
